// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: FTW/offset -> registered LUT address, one edge after each advance.
// FTW handshake stalls (ftw_ready_o low) while a wrap-aligned word is waiting to transfer.
module dds_phase_accumulator #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  phase_clear_i,
    input  logic                  update_at_wrap_i,
    input  logic [ACC_WIDTH-1:0]  ftw_i,
    input  logic                  ftw_valid_i,
    output logic                  ftw_ready_o,
    input  logic [ADDR_WIDTH-1:0] phase_offset_i,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  address_valid_o,
    output logic                  wrap_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    r_active_ftw;
    logic [ACC_WIDTH-1:0]    r_pending_ftw;
    logic [ACC_WIDTH:0]      w_sum;
    logic [ACC_WIDTH-1:0]    w_acc_next;
    logic                    w_carry;
    logic                    w_accept;
    logic                    w_transfer;
    logic [ADDR_WIDTH-1:0]   w_addr_next;

    assign w_accept = ftw_valid_i && ftw_ready_o;
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_active_ftw};

    always_comb begin
        w_acc_next = r_acc;
        w_carry    = 1'b0;
        if (phase_clear_i) begin
            w_acc_next = '0;
        end else if (enable_i) begin
            w_acc_next = w_sum[ACC_WIDTH-1:0];
            w_carry    = w_sum[ACC_WIDTH];
        end
    end

    // A zero active FTW never wraps, so any enabled edge releases the pending word.
    assign w_transfer = (r_state == PENDING) &&
                        (phase_clear_i ||
                         (enable_i && (w_carry || (r_active_ftw == '0))));

    assign w_addr_next = w_acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && update_at_wrap_i) w_state_next = PENDING;
            PENDING: if (w_transfer)                   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ftw_ready_o = (r_state == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc           <= '0;
            r_active_ftw    <= '0;
            r_pending_ftw   <= '0;
            address_o       <= '0;
            address_valid_o <= 1'b0;
            wrap_o          <= 1'b0;
        end else begin
            r_acc           <= w_acc_next;
            address_o       <= w_addr_next;
            address_valid_o <= enable_i | phase_clear_i;
            wrap_o          <= w_carry;
            if (w_accept && !update_at_wrap_i) begin
                r_active_ftw <= ftw_i;
            end else if (w_transfer) begin
                r_active_ftw <= r_pending_ftw;
            end
            if (w_accept && update_at_wrap_i) begin
                r_pending_ftw <= ftw_i;
            end
        end
    end

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase accumulator for the DDS datapath. It sits directly upstream of `sine_lut` and produces the 8-bit LUT address from a programmable frequency tuning word (FTW) and a phase offset. FTWs load through a valid/ready handshake, either immediately or phase-continuously at the next accumulator wrap. A registered wrap pulse marks each completed output period.

## Interface

- `ACC_WIDTH`, default 32: accumulator and FTW width.
- `ADDR_WIDTH`, default 8: output address width. Must be ≤ `ACC_WIDTH` and must match the `sine_lut` address width.

- `clk_i`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `enable_i`, input, 1: advances the accumulator when high.
- `phase_clear_i`, input, 1: synchronous accumulator clear. Takes priority over `enable_i`.
- `update_at_wrap_i`, input, 1: FTW load mode. 0 = immediate, 1 = at wrap.
- `ftw_i`, input, `ACC_WIDTH`: frequency tuning word.
- `ftw_valid_i`, input, 1: `ftw_i` is valid.
- `ftw_ready_o`, output, 1: block can accept an FTW.
- `phase_offset_i`, input, `ADDR_WIDTH`: phase offset added to the address.
- `address_o`, output, `ADDR_WIDTH`: registered LUT address, drives `sine_lut` `address_i`.
- `address_valid_o`, output, 1: `address_o` reflects an enabled advance.
- `wrap_o`, output, 1: one-cycle pulse after an accumulator overflow.

## Operation

- **State.**
  - `acc` (`ACC_WIDTH`), `active_ftw`, `pending_ftw`.
  - Pending-state machine with two states: `IDLE` (pending=0) and `PENDING` (pending=1).
  - `ftw_ready_o = (state == IDLE)`.
- **Reset values.** `acc`=0, `active_ftw`=0, `pending_ftw`=0, state=`IDLE`, `ftw_ready_o`=1, `address_o`=0, `address_valid_o`=0, `wrap_o`=0.
- **Accept.** An FTW is accepted on an edge where `ftw_valid_i && ftw_ready_o`.
  - With `update_at_wrap_i`=0: `active_ftw <= ftw_i`. State stays `IDLE`.
  - With `update_at_wrap_i`=1: `pending_ftw <= ftw_i`, state goes to `PENDING`.
- **PENDING → IDLE transitions.** On the edge where any of the following occurs, `active_ftw <= pending_ftw`:
  - an enabled advance produces a carry out;
  - `phase_clear_i`=1;
  - an enabled edge occurs with `active_ftw`==0 (deadlock avoidance).
- **Accumulation.**
  - `phase_clear_i`=1: `acc <= 0`, carry = 0.
  - Else `enable_i`=1: `{carry, acc} <= acc + active_ftw`, using the pre-edge `active_ftw`. Modulo 2^`ACC_WIDTH`; the carry is the overflow bit.
  - Else: `acc` holds, carry = 0.
- **Address.** Updated every edge:
  - `acc_next` is the value `acc` takes at that edge.
  - `address_o <= acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset_i`, modulo 2^`ADDR_WIDTH` (carry discarded).
- **Flags.**
  - `address_valid_o <= enable_i | phase_clear_i`.
  - `wrap_o <= carry`.
- **Mode change while `PENDING`.** The pending word still transfers only by the `PENDING` rules above.
- **No accept while `PENDING`.** `ftw_valid_i` is ignored; the upstream source must hold its data.

## Timing

- **FTW effect.** An accepted immediate FTW affects the advance on the edge after acceptance, not the accept edge.
- **Address latency.** `address_o` reflects `acc` one edge after the advance, with no further latency. The LUT output is combinational, so the sine sample is valid in the same cycle.
- **Ready timing.**
  - `ftw_ready_o` falls the cycle after a wrap-mode accept.
  - It rises the cycle after the transfer edge.
  - Minimum `PENDING` dwell is 1 cycle.
- **`wrap_o`** is high for exactly one cycle per overflow. It is never asserted on a clear edge.
- **`phase_clear_i`** with `enable_i`=1: clear wins, `address_o` = `phase_offset_i`, `wrap_o`=0.
- **Async reset mid-operation.** All state and outputs go to reset values immediately, independent of `clk_i`. Operation resumes on the first edge after `rst_n_i` rises; any pending FTW is discarded.

## Test plan

All scenarios use `ACC_WIDTH`=32, `ADDR_WIDTH`=8.

- **Reset.** Assert `rst_n_i`=0 → `address_o`=0x00, `wrap_o`=0, `address_valid_o`=0, `ftw_ready_o`=1, with no clock needed.
- **Immediate load, slow step.** Immediate load of FTW 0x0100_0000, then `enable_i`=1 → `address_o` steps 0x01, 0x02, …, 0xFF, 0x00. `wrap_o`=1 only in the cycle `address_o` returns to 0x00, after 256 advances.
- **Immediate load, quarter step.** FTW 0x4000_0000 → `address_o` sequence 0x40, 0x80, 0xC0, 0x00, with `wrap_o` on the fourth.
- **Wrap-mode load.**
  - Setup: active FTW 0x4000_0000; at `address_o`=0x40, load 0x8000_0000 with `update_at_wrap_i`=1.
  - Required: `ftw_ready_o` drops the next cycle. A second valid FTW is ignored.
  - Addresses continue 0x80, 0xC0, 0x00 (transfer on this wrap edge), then 0x80, 0x00.
  - `ftw_ready_o` returns high after the transfer.
- **Offset, zero FTW, and clear.**
  - FTW 0 and `phase_offset_i`=0x40 → `address_o`=0x40 constant, `wrap_o` never set. A wrap-mode load of 0x0100_0000 transfers on the next enabled edge.
  - `phase_clear_i` while `enable_i`=1 at `address_o`=0x90 → next `address_o`=0x40, `wrap_o`=0.
- **Reset mid-operation.** Assert `rst_n_i` while in `PENDING` → outputs reset at once, the pending FTW is lost, and after release with `enable_i`=1, `address_o` stays at the offset value (FTW 0).
